// File: rtl/joypad_port_ctrl_if.sv
// rtl/joypad_port_ctrl_if.sv - Pad source inputs, CPU port strobes and serial read-back signals
interface joypad_port_ctrl_if;
   logic       usb_gamepad_ena;
   logic [7:0] usb_gamepad_data;
   logic       uart_pad_ena;
   logic [7:0] uart_pad_data;
   logic       swap;
   logic       jp_wr;
   logic       jp_wr_data;
   logic       jp1_rd;
   logic       jp2_rd;
   logic       jp1_dout;
   logic       jp2_dout;
   logic [1:0] pad_valid;

   modport master (
      output usb_gamepad_ena,
      output usb_gamepad_data,
      output uart_pad_ena,
      output uart_pad_data,
      output swap,
      output jp_wr,
      output jp_wr_data,
      output jp1_rd,
      output jp2_rd,
      input  jp1_dout,
      input  jp2_dout,
      input  pad_valid
   );

   modport slave (
      input  usb_gamepad_ena,
      input  usb_gamepad_data,
      input  uart_pad_ena,
      input  uart_pad_data,
      input  swap,
      input  jp_wr,
      input  jp_wr_data,
      input  jp1_rd,
      input  jp2_rd,
      output jp1_dout,
      output jp2_dout,
      output pad_valid
   );
endinterface

// File: rtl/joypad_port_ctrl.sv
// rtl/joypad_port_ctrl.sv - Two-source pad capture with staleness timeout feeding two NES-style serial ports
module joypad_port_ctrl #(
   parameter int TIMEOUT = 2400000
) (
   input  logic              clk24,
   input  logic              rst,
   joypad_port_ctrl_if.slave bus
);
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

   typedef enum logic {
      SHIFT  = 1'b0,
      RELOAD = 1'b1
   } port_mode_t;

   // Source index 0 is USB, 1 is UART.
   logic [1:0]    src_ena;
   logic [7:0]    src_data [2];
   logic [7:0]    hold     [2];
   logic [CW-1:0] stale    [2];
   logic [1:0]    valid;

   port_mode_t    mode;
   logic          swap_q;

   logic [1:0]    port_rd;
   logic [7:0]    port_src [2];
   logic [7:0]    sr       [2];

   assign src_ena     = {bus.uart_pad_ena, bus.usb_gamepad_ena};
   assign src_data[0] = bus.usb_gamepad_data;
   assign src_data[1] = bus.uart_pad_data;
   assign port_rd     = {bus.jp2_rd, bus.jp1_rd};

   // A fresh update always beats an expiring counter.
   always_ff @(posedge clk24) begin
      for (int s = 0; s < 2; s++) begin
         if (!rst) begin
            hold[s]  <= 8'h00;
            valid[s] <= 1'b0;
            stale[s] <= '0;
         end else if (src_ena[s]) begin
            hold[s]  <= src_data[s];
            valid[s] <= 1'b1;
            stale[s] <= '0;
         end else if (stale[s] == CNT_MAX) begin
            hold[s]  <= 8'h00;
            valid[s] <= 1'b0;
         end else begin
            stale[s] <= stale[s] + CW'(1);
         end
      end
   end

   // swap is only followed while the strobe is high, so a read sequence sees one mapping.
   always_ff @(posedge clk24) begin
      if (!rst) begin
         mode   <= SHIFT;
         swap_q <= 1'b0;
      end else begin
         if (mode == RELOAD) begin
            swap_q <= bus.swap;
         end
         if (bus.jp_wr) begin
            mode <= port_mode_t'(bus.jp_wr_data);
         end
      end
   end

   always_comb begin
      port_src[0] = swap_q ? hold[1] : hold[0];
      port_src[1] = swap_q ? hold[0] : hold[1];
   end

   // Decisions use the pre-write mode, so a same-cycle write never alters this edge.
   always_ff @(posedge clk24) begin
      for (int p = 0; p < 2; p++) begin
         if (!rst) begin
            sr[p] <= 8'hFF;
         end else if (mode == RELOAD) begin
            sr[p] <= port_src[p];
         end else if (port_rd[p]) begin
            sr[p] <= {1'b1, sr[p][7:1]};
         end
      end
   end

   assign bus.jp1_dout  = sr[0][0] | ~rst;
   assign bus.jp2_dout  = sr[1][0] | ~rst;
   assign bus.pad_valid = valid & {2{rst}};
endmodule

// File: tb/tb_joypad_port_ctrl.sv
// tb/tb_joypad_port_ctrl.sv - Directed bench for joypad_port_ctrl with a short stale timeout
module tb_joypad_port_ctrl;
   logic clk24 = 1'b0;
   logic rst;
   int   vectors     = 0;
   int   miscompares = 0;
   logic [7:0] pat;
   logic [7:0] pat2;

   joypad_port_ctrl_if jif ();

   joypad_port_ctrl #(.TIMEOUT(16)) dut (
      .clk24 (clk24),
      .rst   (rst),
      .bus   (jif)
   );

   always #5 clk24 = ~clk24;

   task automatic tick(input int n);
      repeat (n) @(posedge clk24);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic usb_load(input logic [7:0] d);
      jif.usb_gamepad_data = d;
      jif.usb_gamepad_ena  = 1'b1;
      tick(1);
      jif.usb_gamepad_ena  = 1'b0;
   endtask

   task automatic strobe_cycle();
      jif.jp_wr      = 1'b1;
      jif.jp_wr_data = 1'b1;
      tick(1);
      jif.jp_wr      = 1'b0;
      tick(1);
      jif.jp_wr      = 1'b1;
      jif.jp_wr_data = 1'b0;
      tick(1);
      jif.jp_wr      = 1'b0;
   endtask

   task automatic rd1(input string tag, input logic b);
      jif.jp1_rd = 1'b1;
      chk(tag, {7'b0, jif.jp1_dout}, {7'b0, b});
      tick(1);
      jif.jp1_rd = 1'b0;
   endtask

   task automatic rd_both(input string tag, input logic b1, input logic b2);
      jif.jp1_rd = 1'b1;
      jif.jp2_rd = 1'b1;
      chk({tag, "_p1"}, {7'b0, jif.jp1_dout}, {7'b0, b1});
      chk({tag, "_p2"}, {7'b0, jif.jp2_dout}, {7'b0, b2});
      tick(1);
      jif.jp1_rd = 1'b0;
      jif.jp2_rd = 1'b0;
   endtask

   initial begin
      rst                  = 1'b0;
      jif.usb_gamepad_ena  = 1'b0;
      jif.usb_gamepad_data = 8'h00;
      jif.uart_pad_ena     = 1'b0;
      jif.uart_pad_data    = 8'h00;
      jif.swap             = 1'b0;
      jif.jp_wr            = 1'b0;
      jif.jp_wr_data       = 1'b0;
      jif.jp1_rd           = 1'b0;
      jif.jp2_rd           = 1'b0;
      tick(2);
      jif.usb_gamepad_data = 8'hFF;
      jif.usb_gamepad_ena  = 1'b1;
      tick(1);
      jif.usb_gamepad_ena  = 1'b0;
      chk("rst_jp1", {7'b0, jif.jp1_dout}, 8'h01);
      chk("rst_jp2", {7'b0, jif.jp2_dout}, 8'h01);
      chk("rst_valid", {6'b0, jif.pad_valid}, 8'h00);
      rst = 1'b1;
      tick(1);

      // Basic USB read sequence on port 1.
      usb_load(8'h09);
      chk("usb_valid", {6'b0, jif.pad_valid}, 8'h01);
      strobe_cycle();
      pat = 8'b0000_1001;
      for (int i = 0; i < 8; i++) rd1($sformatf("seq09_r%0d", i + 1), pat[i]);
      rd1("seq09_r9", 1'b1);

      // Swapped mapping with simultaneous reads on both ports.
      jif.swap             = 1'b1;
      jif.usb_gamepad_data = 8'h01;
      jif.uart_pad_data    = 8'h80;
      jif.usb_gamepad_ena  = 1'b1;
      jif.uart_pad_ena     = 1'b1;
      tick(1);
      jif.usb_gamepad_ena  = 1'b0;
      jif.uart_pad_ena     = 1'b0;
      chk("both_valid", {6'b0, jif.pad_valid}, 8'h03);
      strobe_cycle();
      pat  = 8'b1000_0000;
      pat2 = 8'b0000_0001;
      for (int i = 0; i < 8; i++) rd_both($sformatf("swap_r%0d", i + 1), pat[i], pat2[i]);
      rd_both("swap_r9", 1'b1, 1'b1);

      // Reads while strobe is high return A without shifting; write and read in one cycle.
      jif.swap = 1'b0;
      usb_load(8'h0E);
      jif.jp_wr      = 1'b1;
      jif.jp_wr_data = 1'b1;
      tick(1);
      jif.jp_wr      = 1'b0;
      tick(2);
      rd1("hi_r1", 1'b0);
      rd1("hi_r2", 1'b0);
      rd1("hi_r3", 1'b0);
      jif.jp_wr      = 1'b1;
      jif.jp_wr_data = 1'b0;
      tick(1);
      jif.jp_wr      = 1'b0;
      rd1("lo_r1", 1'b0);
      rd1("lo_r2", 1'b1);
      jif.jp1_rd     = 1'b1;
      jif.jp_wr      = 1'b1;
      jif.jp_wr_data = 1'b1;
      chk("wrrd_dout", {7'b0, jif.jp1_dout}, 8'h01);
      tick(1);
      jif.jp1_rd     = 1'b0;
      jif.jp_wr      = 1'b0;
      chk("wrrd_shifted", {7'b0, jif.jp1_dout}, 8'h01);
      tick(1);
      chk("wrrd_reload", {7'b0, jif.jp1_dout}, 8'h00);
      jif.jp_wr      = 1'b1;
      jif.jp_wr_data = 1'b0;
      tick(1);
      jif.jp_wr      = 1'b0;

      // Holding-register update mid-sequence does not disturb latched bits.
      usb_load(8'h05);
      strobe_cycle();
      rd1("mid_r1", 1'b1);
      rd1("mid_r2", 1'b0);
      usb_load(8'hFF);
      chk("uart_stale", {6'b0, jif.pad_valid}, 8'h01);
      pat = 8'b0000_0101;
      for (int i = 2; i < 8; i++) rd1($sformatf("mid_r%0d", i + 1), pat[i]);
      rd1("mid_r9", 1'b1);
      strobe_cycle();
      for (int i = 0; i < 8; i++) rd1($sformatf("new_r%0d", i + 1), 1'b1);

      // Stale timeout: valid drops on the 16th idle edge and data reads as released.
      usb_load(8'hA5);
      tick(15);
      chk("to_15", {6'b0, jif.pad_valid}, 8'h01);
      tick(1);
      chk("to_16", {6'b0, jif.pad_valid}, 8'h00);
      strobe_cycle();
      for (int i = 0; i < 8; i++) rd1($sformatf("to_r%0d", i + 1), 1'b0);
      rd1("to_r9", 1'b1);

      // Reset in mid-sequence.
      usb_load(8'h00);
      strobe_cycle();
      rd1("pre_rst_r1", 1'b0);
      rd1("pre_rst_r2", 1'b0);
      rd1("pre_rst_r3", 1'b0);
      rst                  = 1'b0;
      jif.jp1_rd           = 1'b1;
      jif.usb_gamepad_data = 8'h00;
      jif.usb_gamepad_ena  = 1'b1;
      tick(1);
      chk("mrst_jp1", {7'b0, jif.jp1_dout}, 8'h01);
      chk("mrst_jp2", {7'b0, jif.jp2_dout}, 8'h01);
      chk("mrst_valid", {6'b0, jif.pad_valid}, 8'h00);
      tick(1);
      rst                 = 1'b1;
      jif.jp1_rd          = 1'b0;
      jif.usb_gamepad_ena = 1'b0;
      chk("post_rst_valid", {6'b0, jif.pad_valid}, 8'h00);
      rd1("post_rst_r1", 1'b1);
      rd1("post_rst_r2", 1'b1);
      rd1("post_rst_r3", 1'b1);
      rd_both("post_rst_both", 1'b1, 1'b1);
      usb_load(8'h00);
      strobe_cycle();
      rd1("restrobe_r1", 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
